btn_debounce_multi: RTL
=======================

// Module: btn_debounce_multi
// PURPOSE
//  Parametrised N-channel push-button conditioner: per-channel 2-FF synchroniser, counter-based
//  stability filter on a shared internal sample tick, then edge, long-press and auto-repeat pulses.
//  Sits between the board buttons and the control FSMs; replaces single-button 8 Hz debounce.
//  All outputs are registered and synchronous to clk_100Mhz.
// PARAMETERS
//  N_CH          4        number of button channels (1..16)
//  TICK_DIV      100000   clk cycles per sample tick (1 ms at 100 MHz); >=2
//  STABLE_TICKS  10       consecutive differing samples needed to accept a new level; >=1
//  LONG_TICKS    1000     ticks of continuous press before btn_long fires; > STABLE_TICKS
//  REPEAT_TICKS  200      ticks between auto-repeat pulses after long press; >=1
//  REPEAT_EN     1        1 = auto-repeat on btn_press, 0 = btn_press is rise only
// PORTS
//  clk_100Mhz  in   1      system clock, 100 MHz, only clock in block
//  rst         in   1      reset, synchronous, active-low (0 = reset)
//  btn_in      in   N_CH   raw asynchronous button inputs, 1 = pressed
//  btn_level   out  N_CH   debounced level per channel
//  btn_rise    out  N_CH   1-cycle pulse when btn_level goes 0->1
//  btn_fall    out  N_CH   1-cycle pulse when btn_level goes 1->0
//  btn_long    out  N_CH   1-cycle pulse when a press has lasted LONG_TICKS ticks
//  btn_press   out  N_CH   1-cycle pulse on rise, plus each auto-repeat (REPEAT_EN=1)
//  tick        out  1      1-cycle sample-tick strobe (debug / shared timebase)
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): prescaler, sync FFs, all counters, all outputs <= 0.
//  - Prescaler: cnt 0..TICK_DIV-1, wraps to 0; tick=1 for the cycle where cnt==TICK_DIV-1.
//  - Sync: sync0<=btn_in, sync1<=sync0 every clk; filter uses sync1 only (2-cycle delay).
//  - Filter per channel, stab_cnt width clog2(STABLE_TICKS+1):
//    sync1==btn_level -> stab_cnt<=0 (any cycle, tick or not);
//    sync1!=btn_level & tick -> if stab_cnt==STABLE_TICKS-1: btn_level<=sync1, stab_cnt<=0
//                               else stab_cnt<=stab_cnt+1.
//    A single glitch sample back to old level restarts the count.
//  - Latency btn_in step -> btn_level: 2 sync cycles + STABLE_TICKS ticks; worst case
//    2+STABLE_TICKS*TICK_DIV cycles, best 2+(STABLE_TICKS-1)*TICK_DIV+1.
//  - btn_rise/btn_fall: asserted in the cycle immediately after btn_level changes, 1 cycle.
//  - Hold FSM per channel: IDLE, PRESS, LONG.
//    IDLE: btn_level=1 -> PRESS, hold_cnt<=0.
//    PRESS: tick -> hold_cnt+1; hold_cnt==LONG_TICKS-1 on tick -> LONG, btn_long pulse,
//           rep_cnt<=0, and if REPEAT_EN a btn_press pulse in the same cycle.
//    LONG: tick -> rep_cnt+1; rep_cnt==REPEAT_TICKS-1 on tick -> rep_cnt<=0, btn_press pulse
//          (REPEAT_EN=1 only).
//    Any state: btn_level=0 -> IDLE, counters cleared, no pulse on release.
//  - btn_press = rise pulse OR repeat pulse; coincident sources give one 1-cycle pulse.
//  - Counters never wrap: hold_cnt stops at LONG_TICKS-1 (state leaves PRESS), rep_cnt resets.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
//  - Reset mid-press: outputs drop to 0 next edge; a still-held button after reset is
//    re-qualified from scratch (full STABLE_TICKS) and produces a fresh btn_rise.
//  - rst mid-tick restarts the prescaler at 0; no partial tick is emitted.
// STRUCTURE
//  - Shared header/package: hold FSM state encodings (IDLE=2'd0, PRESS=2'd1, LONG=2'd2)
//    and a clog2 width function; no board-specific constants.
//  - Top: prescaler + generate loop over N_CH instances of sub-module btn_debounce_ch
//    (sync, filter, edge detect, hold FSM for one channel; inputs clk_100Mhz, rst, tick, raw).
//  - No other clocks; tick is a clock enable, never used as a clock.
// TESTING  (params: N_CH=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2, REPEAT_EN=1)
//  - Reset: rst=0 4 cycles with btn_in=2'b11 -> all outputs 0; after release btn_level stays 0
//    until 3 ticks seen, then btn_level[0]=1 and btn_rise[0] one cycle.
//  - Bounce: btn_in[0] toggles every 3 clks for 40 clks then holds 1 -> exactly one btn_rise,
//    btn_level[0] rises 2+3 ticks after the last toggle at most (<= 14 clks).
//  - Release: after stable press drop btn_in[0] -> one btn_fall, btn_level 0, no btn_press.
//  - Long/repeat: hold btn_in[1] 80 clks -> btn_rise then btn_long 8 ticks after btn_level=1,
//    btn_press at rise, at long, then every 2 ticks (8 clks); release stops pulses.
//  - Independence: press ch0 and ch1 in same cycle -> btn_rise=2'b11 in one cycle; ch1 glitch
//    of 1 tick during ch0 hold -> no ch1 outputs, ch0 repeat cadence unchanged.
//  - Reset mid-hold: rst=0 for 1 cycle while in LONG -> outputs 0; held button re-qualifies
//    after 3 ticks with a new btn_rise, btn_long again 8 ticks later.

Source files
------------

// File: rtl/btn_debounce_multi_pkg.sv
// btn_debounce_multi_pkg: hold FSM encodings and a width helper for the button conditioner
package btn_debounce_multi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, LONG = 2'd2} hold_state_t;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/btn_debounce_multi_ch.sv
// btn_debounce_ch: one channel of sync, stability filter, edge detect and hold/repeat FSM
module btn_debounce_ch
  import btn_debounce_multi_pkg::*;
#(
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse,
  output logic press
);
  localparam int SW = clog2(STABLE_TICKS + 1);
  localparam int HW = clog2(LONG_TICKS);
  localparam int RW = clog2(REPEAT_TICKS);
  logic sync0, sync1, flip, long_hit, rep_hit;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  hold_state_t state, state_nxt;
  always_comb begin
    flip      = (sync1 != level) && tick && (stab_cnt == SW'(STABLE_TICKS - 1));
    long_hit  = (state == PRESS) && tick && (hold_cnt == HW'(LONG_TICKS - 1));
    rep_hit   = (state == LONG) && tick && (rep_cnt == RW'(REPEAT_TICKS - 1));
    state_nxt = !level ? IDLE : (state == IDLE) ? PRESS : long_hit ? LONG : state;
  end
  always_ff @(posedge clk_100Mhz)
    state <= !rst ? IDLE : state_nxt;
  always_ff @(posedge clk_100Mhz) begin
    if (!rst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      level      <= 1'b0;
      stab_cnt   <= '0;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_pulse <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync0      <= raw;
      sync1      <= sync0;
      level      <= flip ? sync1 : level;
      stab_cnt   <= (sync1 == level || flip) ? '0 : tick ? stab_cnt + 1'b1 : stab_cnt;
      hold_cnt   <= (state_nxt != PRESS) ? '0 : (state == PRESS && tick) ? hold_cnt + 1'b1 : hold_cnt;
      rep_cnt    <= (state_nxt != LONG || rep_hit) ? '0 : (state == LONG && tick) ? rep_cnt + 1'b1 : rep_cnt;
      rise       <= flip & sync1;
      fall       <= flip & ~sync1;
      long_pulse <= level & long_hit;
      press      <= (flip & sync1) | ((REPEAT_EN != 0) & level & (long_hit | rep_hit));
    end
  end
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: shared sample-tick prescaler feeding N_CH independent button conditioners
module btn_debounce_multi
  import btn_debounce_multi_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int REPEAT_EN    = 1
) (
  input  logic            clk_100Mhz,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_press,
  output logic            tick
);
  localparam int DW = clog2(TICK_DIV);
  logic [DW-1:0] cnt, cnt_nxt;
  assign cnt_nxt = (cnt == DW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk_100Mhz) begin
    cnt  <= !rst ? '0 : cnt_nxt;
    tick <= rst && (cnt_nxt == DW'(TICK_DIV - 1));
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_ch (
      .clk_100Mhz(clk_100Mhz),
      .rst       (rst),
      .tick      (tick),
      .raw       (btn_in[i]),
      .level     (btn_level[i]),
      .rise      (btn_rise[i]),
      .fall      (btn_fall[i]),
      .long_pulse(btn_long[i]),
      .press     (btn_press[i])
    );
  end
endmodule
